// File: rtl/async_fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// async_fifo_arb_pkg
// Shared types and constants for the async FIFO write arbiter.
//   arb_state_e : arbiter FSM state (IDLE / BURST / STALL)
//   ARB_CNT_W   : width of each per-requester write statistics counter
// ----------------------------------------------------------------------------
package async_fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        STALL = 2'd2
    } arb_state_e;

    localparam int ARB_CNT_W = 16;

endpackage

// File: rtl/async_fifo_rr_picker.sv
// ----------------------------------------------------------------------------
// async_fifo_rr_picker
// Combinational round-robin search: scans req upward starting at ptr,
// wrapping past NREQ-1 back to 0, and reports the first set bit.
// Ports:
//   req   in  [NREQ-1:0]   request vector
//   ptr   in  [IDX_W-1:0]  index at which the search starts
//   valid out              at least one request is set
//   idx   out [IDX_W-1:0]  winning requester (0 when valid is low)
// ----------------------------------------------------------------------------
module async_fifo_rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // NOTE: every variable written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/async_fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// async_fifo_write_arbiter
// Round-robin arbiter that lets NREQ requesters share the write port of an
// async FIFO. A winner owns the port for up to BURST_LEN words; a full FIFO
// parks the burst in STALL, a withdrawn request ends it. The round-robin
// pointer moves to the requester after the owner whenever a burst ends.
//
// Optional feature: define ASYNC_FIFO_ARB_STATS_EN to add wr_count, one
// 16-bit saturating write counter per requester.
//
// Ports:
//   wclk      in   write-domain clock
//   wrst      in   synchronous active-high reset
//   req       in   [NREQ-1:0]        per-requester request, held until ack
//   req_data  in   [NREQ*DSIZE-1:0]  per-requester word, slice i for req[i]
//   ack       out  [NREQ-1:0]        one-hot: word of requester i written now
//   gnt       out  [NREQ-1:0]        one-hot current owner, zero in IDLE
//   winc      out                    FIFO write enable
//   wdata     out  [DSIZE-1:0]       FIFO write data (0 when winc is low)
//   wfull     in                     FIFO full flag
//   busy      out                    high in BURST or STALL
//   wr_count  out  [NREQ*16-1:0]     (stats build only) write counters
// ----------------------------------------------------------------------------
`ifndef DSIZE
`define DSIZE 8
`endif

module async_fifo_write_arbiter
    import async_fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DSIZE     = `DSIZE,
    parameter int BURST_LEN = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       gnt,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    input  logic                  wfull,
    output logic                  busy
`ifdef ASYNC_FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*ARB_CNT_W-1:0] wr_count
`endif
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req;
    logic [IDX_W-1:0] after_owner;
    logic [DSIZE-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign data_arr[g] = req_data[g*DSIZE +: DSIZE];
    end

    assign owner_req   = req[owner_q];
    assign after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    async_fifo_rr_picker #(
        .NREQ (NREQ),
        .IDX_W(IDX_W)
    ) u_picker (
        .req  (req),
        .ptr  (rr_ptr_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    state_d  = IDLE;
                    rr_ptr_d = after_owner;
                end else if (wfull) begin
                    state_d = STALL;
                end else if (cnt_q == LAST_CNT) begin
                    // Final word of the burst: cnt is left as is, IDLE
                    // clears it on the next grant.
                    state_d  = IDLE;
                    rr_ptr_d = after_owner;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STALL: begin
                if (!owner_req) begin
                    state_d  = IDLE;
                    rr_ptr_d = after_owner;
                end else if (!wfull) begin
                    state_d = BURST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet during reset so a burst interrupted by wrst
    // never writes in the reset cycle.
    always_comb begin
        winc  = 1'b0;
        wdata = '0;
        ack   = '0;
        gnt   = '0;
        busy  = 1'b0;
        if (!wrst && state_q != IDLE) begin
            busy         = 1'b1;
            gnt[owner_q] = 1'b1;
            if (state_q == BURST && owner_req && !wfull) begin
                winc         = 1'b1;
                ack[owner_q] = 1'b1;
                wdata        = data_arr[owner_q];
            end
        end
    end

`ifdef ASYNC_FIFO_ARB_STATS_EN
    logic [ARB_CNT_W-1:0] wr_cnt_q [NREQ];

    // NOTE: this small counter array is architectural state that software
    // reads, so it is cleared on reset; a data-storage memory would not be.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < NREQ; i++) wr_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && wr_cnt_q[i] != '1) wr_cnt_q[i] <= wr_cnt_q[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stats
        assign wr_count[g*ARB_CNT_W +: ARB_CNT_W] = wr_cnt_q[g];
    end
`endif

endmodule

// File: doc/async_fifo_write_arbiter.md
ASYNC_FIFO_WRITE_ARBITER -- requirements
Module: async_fifo_write_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of write requesters (2..8).
REQ-002 Parameter DSIZE, `DSIZE, FIFO word width.
REQ-003 Parameter BURST_LEN, 4, maximum words per grant (1..16).
REQ-004 Port wclk  input  1  write-domain clock; all logic on posedge wclk.
REQ-005 Port wrst  input  1  synchronous, active-high reset.
REQ-006 Port req  input  NREQ  per-requester write request; bit i is held high while requester i has a word pending.
REQ-007 Port req_data  input  NREQ*DSIZE  per-requester write word; slice i is valid while req[i] is high.
REQ-008 Port ack  output  NREQ  one-hot pulse; the word on slice i was written this cycle.
REQ-009 Port gnt  output  NREQ  one-hot current owner; zero in IDLE.
REQ-010 Port winc  output  1  FIFO write enable.
REQ-011 Port wdata  output  DSIZE  FIFO write data.
REQ-012 Port wfull  input  1  FIFO full flag.
REQ-013 Port busy  output  1  high in BURST or STALL.

Function
REQ-014 The FSM SHALL have three states: IDLE, BURST and STALL.
REQ-015 IDLE with req nonzero SHALL select a winner by round-robin, starting the search at rr_ptr and ascending with wrap; the next cycle is BURST with owner=winner and cnt=0.
REQ-016 IDLE SHALL remain in IDLE when req is zero.
REQ-017 In BURST, winc SHALL equal req[owner] & ~wfull, combinationally.
REQ-018 wdata SHALL equal req_data[owner] when winc is high, else 0.
REQ-019 ack[owner] SHALL equal winc, and all other ack bits SHALL be 0.
REQ-020 Each write SHALL increment cnt.
REQ-021 A write with cnt==BURST_LEN-1 SHALL end the burst, with the next state IDLE.
REQ-022 In BURST, req[owner] low SHALL end the burst with no write; the next state is IDLE.
REQ-023 In BURST, wfull high with req[owner] high SHALL produce no write; the next state is STALL.
REQ-024 In STALL, winc and ack SHALL be 0.
REQ-025 STALL SHALL return to BURST on the cycle after wfull is sampled low, and cnt SHALL be preserved.
REQ-026 In STALL, req[owner] low SHALL cause a transition to IDLE.
REQ-027 On every burst end, rr_ptr SHALL load (owner+1) mod NREQ.
REQ-028 Requesters SHALL keep req[i] and req_data[i] stable until ack[i]; the arbiter does not buffer data.
REQ-029 Write throughput SHALL be one word per cycle in BURST, with one IDLE bubble between grants.

Reset
REQ-030 While wrst is high, the state SHALL be IDLE, with rr_ptr=0, owner=0 and cnt=0.
REQ-031 While wrst is high, the outputs SHALL be winc=0, wdata=0, ack=0, gnt=0 and busy=0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst with no write in the reset cycle.
REQ-033 After reset, the next arbitration SHALL start at requester 0.

Configuration
REQ-034 With ASYNC_FIFO_ARB_STATS_EN defined, the block SHALL add output wr_count, NREQ*16 bits, holding one 16-bit saturating counter per requester.
REQ-035 Each wr_count counter SHALL increment on its ack and SHALL clear on wrst.
REQ-036 Without ASYNC_FIFO_ARB_STATS_EN, the wr_count port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 Package async_fifo_arb_pkg SHALL hold the state enum typedef arb_state_e (IDLE, BURST, STALL) and the counter width constant ARB_CNT_W=16.
REQ-038 The round-robin search SHALL be a separate combinational sub-module, async_fifo_rr_picker (inputs req and ptr; outputs valid and idx).

Verification
REQ-039 Only req[2] high with BURST_LEN=4 and wfull=0 -> winc high for 4 consecutive cycles with data of requester 2, one IDLE cycle, then a new grant to requester 2.
REQ-040 req=4'b1111 held continuously after reset -> grant order 0,1,2,3,0, with each burst writing 4 words.
REQ-041 wfull pulsed high for 3 cycles after word 2 of a burst -> STALL for 3 cycles, then words 3 and 4 written, 4 acks in total, no duplicated or lost word.
REQ-042 req[1] dropped after 2 words -> burst ends, rr_ptr=2, and the next grant goes to the lowest requesting index at or above 2 (wrapping).
REQ-043 wrst asserted in the middle of a burst -> winc=0 that cycle, gnt=0, and the first grant after reset goes to the lowest requesting index at or above 0.
REQ-044 With ASYNC_FIFO_ARB_STATS_EN defined, 10 writes from requester 3 -> wr_count[3]=10 and other counters 0; a preloaded value of 16'hFFFF stays at 16'hFFFF on a further write.
